// File: rtl/axis_capture_framer_pkg.sv
// Shared types and constants for the capture framer record path.
// Imported by the framer and its FIFO.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } capture_state_t;

  localparam logic [15:0] DROP_MAX       = 16'hFFFF;
  localparam int          MIN_FIFO_DEPTH = 4;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/axis_capture_framer_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
// The output register holds the oldest entry, so capacity is exactly DEPTH.
module axis_sync_fifo
  import capture_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE     = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] COUNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] COUNT_DEPTH = CW'(DEPTH);

  if (DEPTH < MIN_FIFO_DEPTH || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("axis_sync_fifo: DEPTH must be a power of two and at least 4");
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_r;
  logic             empty_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  logic             pop_s;
  logic             push_s;
  logic             load_s;
  logic [CW-1:0]    staged_s;
  logic [CW-1:0]    count_next_s;
  logic [AW-1:0]    load_addr_s;

  // Handshake decode; the output register stays counted until it is popped.
  always_comb begin
    pop_s        = out_valid_r && rd_ready;
    push_s       = wr_valid && (!full_r || pop_s);
    staged_s     = count_r - CW'(out_valid_r);
    load_s       = (!out_valid_r || pop_s) && (staged_s != COUNT_ZERO);
    load_addr_s  = out_valid_r ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    count_next_s = count_r + CW'(push_s) - CW'(pop_s);
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy flags and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= COUNT_ZERO;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == COUNT_DEPTH);
      empty_r <= (count_next_s == COUNT_ZERO);
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= mem_r[load_addr_s];
      end else if (pop_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign rd_valid = out_valid_r;
  assign rd_data  = out_data_r;
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: rtl/axis_capture_framer.sv
// Capture framer: buffers unstallable codec beats and re-emits them as
// frame-delimited AXI4-Stream, dropping and counting beats on overflow.
module axis_capture_framer
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [31:0]           frame_count,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  capture_state_t        state_r;
  capture_state_t        state_next_s;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  len_req_s;
  logic [LEN_WIDTH-1:0]  len_eff_s;
  logic [LEN_WIDTH-1:0]  beat_cnt_r;
  logic [LEN_WIDTH-1:0]  beat_cnt_next_s;
  logic                  frame_start_s;
  logic                  tag_s;
  logic                  wr_en_s;
  logic                  wr_fire_s;
  logic                  drop_s;
  logic                  out_pop_s;
  logic                  len_load_s;
  logic                  s_tready_r;
  logic [31:0]           frame_count_r;
  logic [15:0]           drop_count_r;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  fifo_valid_s;
  logic [DATA_WIDTH:0]   fifo_data_s;

  // Write-side decode; a new frame length only takes effect at a frame boundary.
  always_comb begin
    len_req_s       = (frame_len == LEN_ZERO) ? LEN_ONE : frame_len;
    frame_start_s   = (state_r == RUN) && (beat_cnt_r == LEN_ZERO);
    len_eff_s       = frame_start_s ? len_req_s : len_r;
    len_load_s      = ((state_r == IDLE) && enable) || frame_start_s;
    tag_s           = (beat_cnt_r == (len_eff_s - LEN_ONE));
    wr_en_s         = s_axis_tvalid && ((state_r == RUN) || (state_r == DRAIN));
    out_pop_s       = fifo_valid_s && m_axis_tready;
    wr_fire_s       = wr_en_s && (!fifo_full_s || out_pop_s);
    drop_s          = wr_en_s && !wr_fire_s;
    beat_cnt_next_s = wr_fire_s ? (tag_s ? LEN_ZERO : (beat_cnt_r + LEN_ONE)) : beat_cnt_r;
  end

  // Next-state logic; leaving RUN mid-frame finishes the frame in DRAIN.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next_s = (beat_cnt_next_s != LEN_ZERO) ? DRAIN : IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (wr_fire_s && tag_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register, frame length latch and beat counter.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_r    <= IDLE;
      len_r      <= LEN_ONE;
      beat_cnt_r <= LEN_ZERO;
    end else begin
      state_r <= state_next_s;
      if (len_load_s) begin
        len_r <= len_req_s;
      end
      if (state_r == IDLE) begin
        beat_cnt_r <= LEN_ZERO;
      end else begin
        beat_cnt_r <= beat_cnt_next_s;
      end
    end
  end

  // Status counters and the always-ready indication to the codec.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      s_tready_r    <= 1'b0;
      frame_count_r <= 32'd0;
      drop_count_r  <= 16'd0;
    end else begin
      s_tready_r <= 1'b1;
      if (out_pop_s && fifo_data_s[DATA_WIDTH]) begin
        frame_count_r <= frame_count_r + 32'd1;
      end
      if (drop_s && (drop_count_r != DROP_MAX)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
    end
  end

  axis_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (axis_aclk),
    .rst_n    (axis_aresetn),
    .wr_valid (wr_en_s),
    .wr_data  ({tag_s, s_axis_tdata}),
    .rd_valid (fifo_valid_s),
    .rd_ready (m_axis_tready),
    .rd_data  (fifo_data_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  assign s_axis_tready = s_tready_r;
  assign m_axis_tvalid = fifo_valid_s;
  assign m_axis_tdata  = fifo_data_s[DATA_WIDTH-1:0];
  assign m_axis_tlast  = fifo_data_s[DATA_WIDTH];
  assign frame_count   = frame_count_r;
  assign drop_count    = drop_count_r;
  assign busy          = (state_r != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_axis_capture_framer.sv
// Directed bench for axis_capture_framer: expected beats are queued as they
// are driven and compared against each output handshake.
module tb_axis_capture_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] frame_len;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic [31:0] frame_count;
  logic [15:0] drop_count;
  logic        busy;

  logic [64:0] sb_q[$];
  int          checks = 0;
  int          passed = 0;
  int          seq = 0;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  always #5 clk = ~clk;

  axis_capture_framer #(
    .DATA_WIDTH (64),
    .LEN_WIDTH  (16),
    .FIFO_DEPTH (16)
  ) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .enable        (enable),
    .frame_len     (frame_len),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] next_data();
    seq++;
    return 64'h0123_4567_0000_0000 ^ (64'(seq) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  // One cycle of stimulus: values set here are sampled at the next rising edge.
  task automatic step(input logic v, input logic push, input logic last);
    logic [63:0] d;
    @(posedge clk);
    #1;
    d = v ? next_data() : 64'd0;
    s_tvalid = v;
    s_tdata  = d;
    if (rand_ready) m_tready = ($urandom_range(0, 99) < 30);
    if (push) sb_q.push_back({last, d});
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (sb_q.size() == 0 && !m_tvalid) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 64'(done), 64'd1);
  endtask

  // Output monitor: scoreboard compare on handshake, stability while stalled.
  always @(negedge clk) begin
    logic [64:0] exp_beat;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_tvalid), 64'd1);
        check("stall_data", m_tdata, prev_data);
        check("stall_last", 64'(m_tlast), 64'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        check("unexpected_beat", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp_beat = sb_q.pop_front();
          check("out_data", m_tdata, exp_beat[63:0]);
          check("out_last", 64'(m_tlast), 64'(exp_beat[64]));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_len = 16'd4;
    s_tvalid = 1'b0; s_tdata = 64'd0; m_tready = 1'b1;

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frames", 64'(frame_count), 64'd0);
    check("rst_drops", 64'(drop_count), 64'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("s_tready_after_release", 64'(s_tready), 64'd1);

    // Basic framing: len 4, 12 back-to-back beats
    step(1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, (i % 4) == 3);
      if (i == 1) check("latency_not_yet", 64'(m_tvalid), 64'd0);
      if (i == 2) check("latency_valid", 64'(m_tvalid), 64'd1);
    end
    wait_drain("basic_drain");
    check("basic_frames", 64'(frame_count), 64'd3);
    check("basic_drops", 64'(drop_count), 64'd0);
    check("basic_busy_run", 64'(busy), 64'd1);

    // Overflow: 20 beats into a stalled 16-entry FIFO
    frame_len = 16'd8;
    m_tready  = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, i < 16, (i == 7) || (i == 15));
    step(1'b0, 1'b0, 1'b0);
    check("ovf_drops", 64'(drop_count), 64'd4);
    check("ovf_valid_held", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_frames", 64'(frame_count), 64'd5);

    // Disable mid-frame: frame completes in DRAIN, later beats discarded
    frame_len = 16'd5;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i < 5, i == 4);
      if (i == 2) enable = 1'b0;
    end
    wait_drain("dis_drain");
    check("dis_frames", 64'(frame_count), 64'd6);
    check("dis_drops", 64'(drop_count), 64'd4);
    check("dis_busy", 64'(busy), 64'd0);

    // Length change mid-frame, then zero length
    frame_len = 16'd3;
    step(1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, (i == 2) || (i == 8));
      if (i == 1) frame_len = 16'd6;
    end
    frame_len = 16'd0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    wait_drain("len_drain");
    check("len_frames", 64'(frame_count), 64'd11);

    // Random backpressure at ~30% ready
    frame_len  = 16'd4;
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, (i % 4) == 3);
    wait_drain("bp_drain");
    rand_ready = 1'b0;
    m_tready   = 1'b1;
    check("bp_frames", 64'(frame_count), 64'd14);
    check("bp_drops", 64'(drop_count), 64'd4);

    // Reset mid-frame
    frame_len = 16'd8;
    m_tready  = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 64'(m_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_tvalid), 64'd0);
    check("mid_rst_data", m_tdata, 64'd0);
    check("mid_rst_last", 64'(m_tlast), 64'd0);
    check("mid_rst_s_tready", 64'(s_tready), 64'd0);
    check("mid_rst_frames", 64'(frame_count), 64'd0);
    check("mid_rst_drops", 64'(drop_count), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    sb_q.delete();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("rel_s_tready_before_edge", 64'(s_tready), 64'd0);
    step(1'b0, 1'b0, 1'b0);
    check("rel_s_tready", 64'(s_tready), 64'd1);
    check("rel_frames", 64'(frame_count), 64'd0);
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i == 7);
    wait_drain("rst_drain");
    check("rst_frames_after", 64'(frame_count), 64'd1);
    check("rst_drops_after", 64'(drop_count), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_capture_framer.md
# axis_capture_framer

Record-path stage directly downstream of the codec unit's AXI4-Stream master (CODEC -> DMA). Accepts 64-bit capture beats from the codec, which cannot be stalled, and buffers them in a small FIFO. Drives a frame-delimited AXI4-Stream to the DMA, asserting tlast every frame_len beats. Drops and counts beats on overflow so the codec never sees backpressure.

## Interface
- DATA_WIDTH, 64: stream data width.
- LEN_WIDTH, 16: width of frame_len.
- FIFO_DEPTH, 16: FIFO entries; power of two, minimum 4.

Ports:
- axis_aclk  in  1  stream clock; everything in this block is on this one clock.
- axis_aresetn  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; level-sensitive.
- frame_len  in  LEN_WIDTH  beats per frame; latched at frame start; 0 is treated as 1.
- s_axis_tvalid  in  1  beat valid from codec.
- s_axis_tready  out  1  always-ready indication to codec.
- s_axis_tdata  in  DATA_WIDTH  beat data from codec.
- m_axis_tvalid  out  1  beat valid to DMA.
- m_axis_tready  in  1  DMA ready.
- m_axis_tdata  out  DATA_WIDTH  beat data to DMA.
- m_axis_tlast  out  1  last beat of frame.
- frame_count  out  32  frames delivered; wraps.
- drop_count  out  16  beats dropped; saturates at 0xFFFF.
- busy  out  1  state != IDLE or FIFO not empty.

## Operation
- States:
  - IDLE: input beats are discarded and not counted.
  - RUN: accepted beats are written to the FIFO.
  - DRAIN: RUN behaviour continues until the current frame completes.
- IDLE -> RUN: on the cycle enable=1. In that cycle, latch len = max(frame_len,1) and clear beat_cnt. The first beat written is the first beat with s_axis_tvalid=1 on or after the following cycle.
- RUN -> DRAIN: enable=0 while beat_cnt != 0.
- RUN -> IDLE: enable=0 while beat_cnt == 0.
- DRAIN -> IDLE: on the write of the tlast-tagged beat. DRAIN ignores enable re-assertion until it returns to IDLE.
- Write rules:
  - A beat is written when s_axis_tvalid=1, state is RUN or DRAIN, and the FIFO is not full.
  - Its tlast tag = (beat_cnt == len-1).
  - beat_cnt increments on each write and wraps to 0 after the tagged beat.
  - When frame_len changes mid-frame, the new value takes effect only at the next frame start (beat_cnt==0 in RUN).
- Overflow:
  - A valid beat arriving in RUN or DRAIN while the FIFO is full is dropped and drop_count increments.
  - beat_cnt does not advance on a drop; the tlast tag moves to the next written beat.
- Simultaneous FIFO write and read are allowed, including when the FIFO is full: a read in the same cycle frees a slot and the beat is written, not dropped.
- frame_count increments on an output handshake with m_axis_tlast=1.
- s_axis_tready is registered: 0 in reset, then 1 from the first clock edge after reset release.
- Reset (async assert, any time): FIFO empty, state IDLE, all counters 0, all outputs 0. A partial frame is discarded with no tlast.

## Timing
- Latency from write to output: a beat written at edge t is presented with m_axis_tvalid=1 after edge t+1 (registered first-word fall-through).
- Throughput: 1 beat/cycle sustained when m_axis_tready=1.
- Output AXI rules:
  - m_axis_tdata and m_axis_tlast stay stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a handshake.
  - tvalid does not depend combinationally on tready.
- FIFO full/empty and counters update on the edge following the event.

## Structure
- capture_pkg:
  - capture_state_t enum {IDLE, RUN, DRAIN}.
  - Constants DROP_MAX = 16'hFFFF and MIN_FIFO_DEPTH = 4.
- Sub-module axis_sync_fifo: DATA_WIDTH+1 bits wide (tlast sideband), FIFO_DEPTH entries. Exposes full and empty, and a registered FWFT output with valid/ready.
- The framer contains the state machine, beat counter, length latch, counters and busy.

## Test plan
- Basic framing: frame_len=4, enable=1, 12 back-to-back beats, m_axis_tready=1 -> tlast on output beats 4, 8, 12; frame_count=3; drop_count=0; first tvalid 2 cycles after the first accepted beat.
- Overflow: FIFO_DEPTH=16, frame_len=8, m_axis_tready=0, 20 beats -> 16 stored, drop_count=4. Then tready=1 -> 16 beats out with tlast on beats 8 and 16.
- Disable mid-frame: frame_len=5, enable falls after 2 beats -> 3 more beats accepted with tlast on the 5th, then IDLE. Further beats are discarded, drop_count unchanged, busy=0 once the FIFO empties.
- Length change and zero: frame_len=3 for the first frame, changed to 6 mid-frame -> first tlast at beat 3, next at beat 9. frame_len=0 -> tlast on every beat.
- Backpressure stability: random m_axis_tready with 30% duty -> tdata and tlast stay stable while stalled; output sequence equals the input sequence; no drops while FIFO occupancy stays below 16.
- Reset mid-frame: assert axis_aresetn=0 after 3 of 8 beats -> all outputs 0 immediately. After release, s_axis_tready=1 after one edge, counters are 0, and the next frame starts fresh with tlast at beat 8.
